// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions for the fetch slice: the canonical NOP, the fetch
// state encoding and the architectural register width.
package rv32i_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FS_RESET = 2'd0,
    FS_RUN   = 2'd1,
    FS_ERROR = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/ifetch_rv32i_if.sv
// Fetch-side bus: ROM address/data pair, the decode handshake and the redirect
// input from branch/jump resolution.
//
// Handshake: a word on fetch_pc/fetch_instr transfers on a rising edge where
// fetch_valid and fetch_ready are both high. While fetch_valid is high and
// fetch_ready is low the word is held unchanged. fetch_valid may drop without
// a transfer only when the word is killed by a redirect.
interface ifetch_rv32i_if;
  import rv32i_pkg::*;

  logic [XLEN-1:0] rom_pc;
  logic [XLEN-1:0] rom_instr;
  logic            fetch_valid;
  logic            fetch_ready;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] fetch_instr;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  // Fetch unit view.
  modport master (
    output rom_pc,
    input  rom_instr,
    output fetch_valid,
    input  fetch_ready,
    output fetch_pc,
    output fetch_instr,
    input  redirect_valid,
    input  redirect_pc
  );

  // Environment view (ROM, decode, branch unit).
  modport slave (
    input  rom_pc,
    output rom_instr,
    input  fetch_valid,
    output fetch_ready,
    input  fetch_pc,
    input  fetch_instr,
    output redirect_valid,
    output redirect_pc
  );

endinterface

// File: rtl/ifetch_nextpc_sel.sv
// Next fetch-address priority mux: redirect beats increment beats hold.
// Also flags a redirect target that is not word aligned.
module ifetch_nextpc_sel
  import rv32i_pkg::*;
(
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            advance,
  input  logic [XLEN-1:0] cur_pc,
  output logic [XLEN-1:0] next_pc,
  output logic            misaligned
);

  // Select the address the ROM should capture on the next edge.
  always_comb begin
    next_pc = cur_pc;
    if (redirect_valid) begin
      next_pc = redirect_pc;
    end else if (advance) begin
      next_pc = cur_pc + 32'd4;  // modulo 2^32, wraps to 0
    end
  end

  assign misaligned = redirect_valid & (redirect_pc[1:0] != 2'b00);

endmodule

// File: rtl/ifetch_rv32i.sv
// Instruction-fetch initiator for the single-cycle RV32I core. Drives the PC
// of a 1-cycle-latency synchronous ROM, holds the word under back-pressure and
// kills the wrong-path word in the same cycle a redirect arrives.
// Optional macro IFETCH_PERF_CNT_EN adds fetched/bubble performance counters.
module ifetch_rv32i
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ROM_AW   = 5
) (
  input  logic               clock,
  input  logic               reset_n,
  ifetch_rv32i_if.master     bus,
  output logic               misalign_err,
  output fetch_state_t       state_dbg,
  output logic [ROM_AW-1:0]  rom_idx_dbg
`ifdef IFETCH_PERF_CNT_EN
  ,
  input  logic               perf_clr,
  output logic [XLEN-1:0]    perf_fetched,
  output logic [XLEN-1:0]    perf_bubbles
`endif
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q;
  logic            inflight_q;

  logic            fetch_valid_c;
  logic            redir_en;
  logic            advance;
  logic [XLEN-1:0] hold_pc;
  logic [XLEN-1:0] next_pc;
  logic            misaligned;

  // Per-state decode: which word is valid, whether a redirect is honoured and
  // which address to hold when not advancing.
  always_comb begin
    fetch_valid_c = 1'b0;
    redir_en      = 1'b0;
    hold_pc       = pc_q;
    case (state_q)
      FS_RESET: begin
        redir_en = bus.redirect_valid;
        hold_pc  = RESET_PC;
      end
      FS_RUN: begin
        fetch_valid_c = inflight_q & ~bus.redirect_valid;
        redir_en      = bus.redirect_valid;
      end
      default: begin
        // ERROR: frozen, redirects ignored
      end
    endcase
  end

  assign advance = fetch_valid_c & bus.fetch_ready;

  ifetch_nextpc_sel u_nextpc_sel (
    .redirect_valid (redir_en),
    .redirect_pc    (bus.redirect_pc),
    .advance        (advance),
    .cur_pc         (hold_pc),
    .next_pc        (next_pc),
    .misaligned     (misaligned)
  );

  // Next-state logic: a misaligned redirect traps into ERROR until reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FS_RESET: state_d = misaligned ? FS_ERROR : FS_RUN;
      FS_RUN:   state_d = misaligned ? FS_ERROR : FS_RUN;
      FS_ERROR: state_d = FS_ERROR;
      default:  state_d = FS_RESET;
    endcase
  end

  // State, fetch address and sticky error registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= FS_RESET;
      pc_q         <= RESET_PC;
      inflight_q   <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q != FS_ERROR) begin
        pc_q <= next_pc;
      end
      inflight_q   <= (state_d == FS_RUN);
      misalign_err <= misalign_err | misaligned;
    end
  end

  assign bus.rom_pc      = next_pc;
  assign bus.fetch_valid = fetch_valid_c;
  assign bus.fetch_pc    = pc_q;
  assign bus.fetch_instr = fetch_valid_c ? bus.rom_instr : NOP_INSTR;

  assign state_dbg   = state_q;
  assign rom_idx_dbg = next_pc[ROM_AW+1:2];

`ifdef IFETCH_PERF_CNT_EN
  // Delivered-word and bubble counters; clear wins over increment.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_fetched <= '0;
      perf_bubbles <= '0;
    end else if (perf_clr) begin
      perf_fetched <= '0;
      perf_bubbles <= '0;
    end else begin
      if (advance) begin
        perf_fetched <= perf_fetched + 32'd1;
      end
      if ((state_q == FS_RUN) && !fetch_valid_c) begin
        perf_bubbles <= perf_bubbles + 32'd1;
      end
    end
  end
`endif

endmodule
